tpu_cfg_regs: RTL

APB3 configuration and status register block that sits directly upstream of the TPU top-level controller. The host uses it to select stages (enable_matmul/norm/pool/activation) and launch a run via start_tpu. It also observes done_tpu, records busy/done status and run cycle count, and raises an interrupt. Because the controller's done_tpu is sticky until reset, this block also issues a soft-reset pulse so the host can re-arm the controller between runs.

---
 rtl/tpu_cfg_pkg.sv | 30 +++
 rtl/tpu_cfg_apb_if.sv | 37 +++
 rtl/tpu_cfg_regs.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tpu_cfg_pkg.sv
// Shared definitions for the TPU config/status register block:
// register offsets, CTRL/STATUS bit indices, FSM and register enums.
package tpu_cfg_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN = 8'h0C;

  localparam int CTRL_START    = 0;
  localparam int CTRL_MATMUL   = 1;
  localparam int CTRL_SOFT_RST = 5;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_CLR
  } state_e;

  typedef enum logic [1:0] {
    R_CTRL,
    R_STATUS,
    R_CYCLES,
    R_IRQ_EN
  } reg_e;

endpackage

// File: rtl/tpu_cfg_apb_if.sv
// APB3 access decoder for the TPU config block.
// Ports: psel/penable/pwrite/paddr in; wr_en/rd_en/addr/addr_err out.
module tpu_cfg_apb_if
  import tpu_cfg_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              wr_en,
  output logic              rd_en,
  output reg_e              addr,
  output logic              addr_err
);

  logic access;
  logic hit;

  always_comb begin
    access = psel & penable;
    hit    = 1'b1;
    addr   = R_CTRL;
    unique case (1'b1)
      (paddr == ADDR_W'(OFF_CTRL)):   addr = R_CTRL;
      (paddr == ADDR_W'(OFF_STATUS)): addr = R_STATUS;
      (paddr == ADDR_W'(OFF_CYCLES)): addr = R_CYCLES;
      (paddr == ADDR_W'(OFF_IRQ_EN)): addr = R_IRQ_EN;
      default:                        hit  = 1'b0;
    endcase
    wr_en    = access & pwrite & hit;
    rd_en    = access & ~pwrite & hit;
    addr_err = access & ~hit;
  end

endmodule

// File: rtl/tpu_cfg_regs.sv
// APB3 config/status registers and run FSM upstream of the TPU controller.
// Ports: APB3 slave, start/enables/soft-reset to controller, done_tpu in, irq out.
module tpu_cfg_regs
  import tpu_cfg_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              start_tpu,
  output logic              enable_matmul,
  output logic              enable_norm,
  output logic              enable_pool,
  output logic              enable_activation,
  output logic              tpu_soft_reset,
  input  logic              done_tpu,
  output logic              irq
);

  logic wr_en, rd_en, addr_err;
  reg_e addr;

  tpu_cfg_apb_if #(.ADDR_W(ADDR_W)) u_apb_if (
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .addr_err (addr_err)
  );

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [3:0]       en_q, en_d;
  logic             srst_q, srst_d;
  logic             done_q;
  logic             stat_done_q, stat_done_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic ctrl_wr, wr_start, wr_srst;
  logic start_ok, start_err, done_rise, busy;
  logic unused_wdata;

  assign unused_wdata = ^pwdata[31:6];

  always_comb begin
    done_rise = done_tpu & ~done_q;
    ctrl_wr   = wr_en & (addr == R_CTRL);
    wr_start  = ctrl_wr & pwdata[CTRL_START];
    wr_srst   = ctrl_wr & pwdata[CTRL_SOFT_RST];
    start_ok  = wr_start & pwdata[CTRL_MATMUL]
              & (state_q == S_IDLE);
    start_err = wr_start & ~start_ok;

    state_d     = state_q;
    start_d     = start_q;
    en_d        = en_q;
    srst_d      = wr_srst;
    stat_done_d = stat_done_q;
    irq_en_d    = irq_en_q;
    cycles_d    = cycles_q;

    // Enables are frozen once a run is launched.
    if (ctrl_wr && state_q == S_IDLE)
      en_d = pwdata[CTRL_MATMUL +: 4];
    if (wr_en && addr == R_IRQ_EN)
      irq_en_d = pwdata[0];
    if (wr_en && addr == R_STATUS && pwdata[ST_DONE])
      stat_done_d = 1'b0;
    if (state_q == S_RUN && cycles_q != '1)
      cycles_d = cycles_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_RUN;
          start_d     = 1'b1;
          cycles_d    = '0;
          stat_done_d = 1'b0;
        end
      end
      S_RUN: begin
        // Done edge beats a same-cycle W1C; soft reset still wins on state.
        if (done_rise) begin
          start_d     = 1'b0;
          stat_done_d = 1'b1;
          state_d     = S_WAIT_CLR;
        end
        if (wr_srst) begin
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WAIT_CLR: begin
        if (wr_srst)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      en_q        <= '0;
      srst_q      <= 1'b0;
      done_q      <= 1'b0;
      stat_done_q <= 1'b0;
      irq_en_q    <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      en_q        <= en_d;
      srst_q      <= srst_d;
      done_q      <= done_tpu;
      stat_done_q <= stat_done_d;
      irq_en_q    <= irq_en_d;
      cycles_q    <= cycles_d;
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    prdata = '0;
    if (rd_en) begin
      unique case (addr)
        R_CTRL:   prdata = {26'b0, 1'b0, en_q, 1'b0};
        R_STATUS: prdata = {30'b0, stat_done_q, busy};
        R_CYCLES: prdata = 32'(cycles_q);
        R_IRQ_EN: prdata = {31'b0, irq_en_q};
        default:  prdata = '0;
      endcase
    end
  end

  assign pready            = 1'b1;
  assign pslverr           = addr_err | start_err;
  assign start_tpu         = start_q;
  assign enable_matmul     = en_q[0];
  assign enable_norm       = en_q[1];
  assign enable_pool       = en_q[2];
  assign enable_activation = en_q[3];
  assign tpu_soft_reset    = srst_q;
  assign irq               = stat_done_q & irq_en_q;

endmodule
